// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine driving the HI/LO register pair.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [63:0] hilo_d,
    output logic [1:0]  hilo_write
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX, ST_DONE} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;      // product accumulator, or {remainder, quotient}
    logic [31:0] mcand_q;    // multiplicand or divisor magnitude
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic [63:0] res_q;
    logic        busy_q;
    logic [63:0] hilo_d_q;
    logic [1:0]  hilo_write_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_new;
    logic [63:0] div_next;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;
    logic [63:0] fix_res;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[31];
        b_neg     = is_signed & b[31];
        a_abs     = a_neg ? -a : a;
        b_abs     = b_neg ? -b : b;

        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};
        mul_next = {mul_sum, acc_q[31:1]};

        rem_sh   = {acc_q[63:32], acc_q[31]};
        rem_ge   = rem_sh >= {1'b0, mcand_q};
        rem_new  = rem_ge ? 32'(rem_sh - {1'b0, mcand_q}) : rem_sh[31:0];
        div_next = {rem_new, acc_q[30:0], rem_ge};

        fix_quo = acc_q[31:0];
        fix_rem = acc_q[63:32];
        fix_res = neg_res_q ? -acc_q : acc_q;
        if (is_div_q) begin
            if (mcand_q == 32'd0) begin
                fix_quo = 32'hFFFF_FFFF;
            end else if (neg_res_q) begin
                fix_quo = -acc_q[31:0];
            end
            if (neg_rem_q) begin
                fix_rem = -acc_q[63:32];
            end
            fix_res = {fix_rem, fix_quo};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            is_div_q     <= 1'b0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            res_q        <= '0;
            busy_q       <= 1'b0;
            hilo_d_q     <= '0;
            hilo_write_q <= 2'b00;
        end else begin
            hilo_write_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MTHI: begin
                                hilo_d_q     <= {a, a};
                                hilo_write_q <= 2'b10;
                            end
                            OP_MTLO: begin
                                hilo_d_q     <= {a, a};
                                hilo_write_q <= 2'b01;
                            end
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q  <= op[1];
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= op[1] & a_neg;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                if (op[1]) begin
                                    acc_q   <= {32'd0, a_abs};
                                    mcand_q <= b_abs;
                                    state_q <= ST_ITER;
                                end else begin
`ifdef MULDIV_FAST_MUL_EN
                                    acc_q   <= {32'd0, a_abs} * {32'd0, b_abs};
                                    mcand_q <= a_abs;
                                    state_q <= ST_FIX;
`else
                                    acc_q   <= {32'd0, b_abs};
                                    mcand_q <= a_abs;
                                    state_q <= ST_ITER;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ITER: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        res_q   <= fix_res;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Commit is unconditional; a late cancel cannot retract it.
                    hilo_d_q     <= res_q;
                    hilo_write_q <= 2'b11;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign hilo_d     = hilo_d_q;
    assign hilo_write = hilo_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected writes, a monitor pops and compares.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [63:0] hilo_d;
    logic [1:0]  hilo_write;

    typedef struct {
        int          cyc;
        logic [1:0]  wr;
        logic [63:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   e0;

    muldiv_unit #(.ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .hilo_d     (hilo_d),
        .hilo_write (hilo_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (rst && hilo_write !== 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {62'd0, hilo_write}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("hilo_write", {62'd0, hilo_write}, {62'd0, mon_e.wr});
                check("hilo_d", hilo_d, mon_e.d);
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 of the cycle after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] wr, input logic [63:0] d, input int lat);
        exp_t e;
        start = 1'b1;
        op = o;
        a = av;
        b = bv;
        e0 = cyc + 1;
        e.cyc = e0 + lat;
        e.wr = wr;
        e.d = d;
        sb.push_back(e);
        @(negedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
        check("busy_after_start", {63'd0, busy}, {63'd0, (lat > 0)});
    endtask

    task automatic raw_start(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op = o;
        a = av;
        b = bv;
        e0 = cyc + 1;
        @(negedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_done"}, 64'(sb.size()), 64'd0);
        check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo_write", {62'd0, hilo_write}, 64'd0);
        check("reset_hilo_d", hilo_d, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
        wait_done("multu_max");
        // Issued directly in the write cycle: must be accepted there.
        issue(OP_MULT, -32'sd7, 32'd3, 2'b11, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        wait_done("mult_neg");
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'd1, MUL_LAT);
        wait_done("mult_m1m1");
        issue(OP_MULT, 32'h7FFF_FFFF, 32'd2, 2'b11, 64'h0000_0000_FFFF_FFFE, MUL_LAT);
        wait_done("mult_big");
        issue(OP_DIV, -32'sd7, 32'd2, 2'b11, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT);
        wait_done("div_neg_dividend");
        issue(OP_DIV, 32'd7, -32'sd2, 2'b11, {32'd1, 32'hFFFF_FFFD}, DIV_LAT);
        wait_done("div_neg_divisor");
        issue(OP_DIVU, 32'd100, 32'd0, 2'b11, {32'd100, 32'hFFFF_FFFF}, DIV_LAT);
        wait_done("divu_by_zero");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 2'b11, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, DIV_LAT);
        wait_done("div_by_zero");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, {32'd0, 32'h8000_0000}, DIV_LAT);
        wait_done("div_overflow");
        issue(OP_MTHI, 32'h1234_5678, 32'd0, 2'b10, 64'h1234_5678_1234_5678, 0);
        wait_done("mthi");
        issue(OP_MTLO, 32'hCAFE_BABE, 32'd0, 2'b01, 64'hCAFE_BABE_CAFE_BABE, 0);
        wait_done("mtlo");

        // A start pulsed mid-operation must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 2'b11, {32'd2, 32'd14}, DIV_LAT);
        wait_cyc(e0 + 5);
        start = 1'b1;
        op = OP_MULT;
        a = 32'd9;
        b = 32'd9;
        @(negedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
        wait_done("divu_ignore_start");

        // Cancel in the DONE cycle does not stop the commit.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 2'b11, {32'hF, 32'h0FFF_FFFF}, DIV_LAT);
        wait_cyc(e0 + DIV_LAT - 1);
        cancel = 1'b1;
        @(negedge clk);
        #1;
        cancel = 1'b0;
        wait_done("cancel_in_done");

        // Cancel in ITER after an ignored start: busy falls, no write at all.
        raw_start(OP_DIVU, 32'd1000, 32'd3);
        wait_cyc(e0 + 5);
        start = 1'b1;
        op = OP_MULTU;
        @(negedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
        wait_cyc(e0 + 20);
        check("busy_before_cancel", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        #1;
        cancel = 1'b0;
        check("busy_after_cancel", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        #1;
        issue(OP_MULTU, 32'd3, 32'd4, 2'b11, 64'd12, MUL_LAT);
        wait_done("multu_after_cancel");

        // Cancel in FIX.
        raw_start(OP_DIV, 32'd50, 32'd5);
        wait_cyc(e0 + 32);
        cancel = 1'b1;
        @(negedge clk);
        #1;
        cancel = 1'b0;
        check("busy_after_fix_cancel", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        #1;

        // Cancel in IDLE blocks the same-cycle start.
        cancel = 1'b1;
        raw_start(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        cancel = 1'b1;
        raw_start(OP_MULTU, 32'd5, 32'd5);
        cancel = 1'b0;
        check("busy_cancel_idle", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        #1;

        // Asynchronous reset mid-divide.
        raw_start(OP_DIV, 32'd77, 32'd3);
        wait_cyc(e0 + 10);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hilo_write", {62'd0, hilo_write}, 64'd0);
        check("rst_mid_hilo_d", hilo_d, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        repeat (40) @(negedge clk);
        #1;
        issue(OP_MULTU, 32'd2, 32'd2, 2'b11, 64'd4, MUL_LAT);
        wait_done("multu_after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
